// File: rtl/tl_sensor_front_pkg.sv
// Shared definitions for the left-turn controller sensor front end:
// light codes, lane numbering and the per-lane serving decode.
package tl_sensor_front_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'b00,
    YELLOW = 2'b01,
    RED    = 2'b10,
    LEFT   = 2'b11
  } light_e;

  localparam int NUM_LANES = 4;

  // Lane order matches the urgent vector: {bl, b, al, a}
  localparam int LANE_A  = 0;
  localparam int LANE_AL = 1;
  localparam int LANE_B  = 2;
  localparam int LANE_BL = 3;

  // One bit per lane: the controller is currently showing that lane its light
  function automatic logic [NUM_LANES-1:0] serve_vec(input logic [1:0] la,
                                                     input logic [1:0] lb);
    serve_vec = {lb == LEFT, lb == GREEN, la == LEFT, la == GREEN};
  endfunction

endpackage

// File: rtl/tl_debounce.sv
// Two-flop synchronizer followed by a level debouncer: the output only
// follows the synchronized input after DEB_CYCLES consecutive differing samples.
module tl_debounce #(
  parameter int DEB_CYCLES = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic             s1, s2;
  logic [CNT_W-1:0] cnt;

  // Synchronize, then count consecutive disagreeing samples before toggling
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      cnt  <= '0;
      dout <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s2 == dout) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
        dout <= ~dout;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/tl_sensor_front.sv
// Detector front end: debounces the four loops, latches each request until
// its light is shown, and flags requests that have waited too long.
module tl_sensor_front
  import tl_sensor_front_pkg::*;
#(
  parameter int DEB_CYCLES = 3,
  parameter int MAX_WAIT   = 15,
  parameter int WAIT_W     = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       det_a,
  input  logic       det_al,
  input  logic       det_b,
  input  logic       det_bl,
  input  logic [1:0] La,
  input  logic [1:0] Lb,
  output logic       Ta,
  output logic       Tal,
  output logic       Tb,
  output logic       Tbl,
  output logic [3:0] urgent
);

  logic [NUM_LANES-1:0]             det;
  logic [NUM_LANES-1:0]             deb;
  logic [NUM_LANES-1:0]             deb_d;
  logic [NUM_LANES-1:0]             pend;
  logic [NUM_LANES-1:0]             serve;
  logic [NUM_LANES-1:0]             urg;
  logic [NUM_LANES-1:0][WAIT_W-1:0] wcnt;

  assign det   = {det_bl, det_b, det_al, det_a};
  assign serve = serve_vec(La, Lb);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    tl_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (det[g]),
      .dout    (deb[g])
    );
  end

  // Request latch: set on the first cycle deb is high, cleared while served
  // (clear wins; deb alone keeps T up if the detector is still occupied)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_d <= '0;
      pend  <= '0;
    end else begin
      deb_d <= deb;
      pend  <= ~serve & (pend | (deb & ~deb_d));
    end
  end

  // Starvation timers: count unserved pending cycles, saturate, flag at the limit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wcnt <= '0;
      urg  <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (!pend[i] || serve[i]) begin
          wcnt[i] <= '0;
          urg[i]  <= 1'b0;
        end else if (wcnt[i] != WAIT_W'(MAX_WAIT)) begin
          wcnt[i] <= wcnt[i] + WAIT_W'(1);
          if (wcnt[i] == WAIT_W'(MAX_WAIT - 1)) urg[i] <= 1'b1;
        end
      end
    end
  end

  assign {Tbl, Tb, Tal, Ta} = deb | pend;
  assign urgent             = urg;

endmodule

// File: tb/tb_tl_sensor_front.sv
// Randomized and directed stimulus for the sensor front end, checked by a
// scoreboard against a behavioural model built from the lane rules.
module tb_tl_sensor_front;

  localparam int DEB = 3;
  localparam int MW  = 15;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       det_a, det_al, det_b, det_bl;
  logic [1:0] La, Lb;
  logic       Ta, Tal, Tb, Tbl;
  logic [3:0] urgent;

  int total = 0;
  int bad   = 0;

  tl_sensor_front #(.DEB_CYCLES(DEB), .MAX_WAIT(MW), .WAIT_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .det_a   (det_a),
    .det_al  (det_al),
    .det_b   (det_b),
    .det_bl  (det_bl),
    .La      (La),
    .Lb      (Lb),
    .Ta      (Ta),
    .Tal     (Tal),
    .Tb      (Tb),
    .Tbl     (Tbl),
    .urgent  (urgent)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Per lane: detector delayed by two edges, a history of the last DEB
  // synchronized samples, the debounced level, the request latch and the
  // number of cycles the request has waited.
  bit m_s1[4], m_s2[4], m_deb[4], m_debprev[4], m_pend[4];
  int m_wait[4];
  bit hist[4][$];
  logic [7:0] exp_q[$];

  function automatic bit served(int lane, logic [1:0] la, logic [1:0] lb);
    case (lane)
      0:       return la == 2'b00;
      1:       return la == 2'b11;
      2:       return lb == 2'b00;
      default: return lb == 2'b11;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_debprev[i] = 0;
      m_pend[i] = 0; m_wait[i] = 0;
      hist[i].delete();
    end
  endtask

  function automatic logic [7:0] model_out();
    logic [3:0] t, u;
    for (int i = 0; i < 4; i++) begin
      t[i] = m_deb[i] | m_pend[i];
      u[i] = (m_wait[i] == MW);
    end
    return {t, u};
  endfunction

  task automatic model_edge();
    bit det[4];
    det = '{det_a, det_al, det_b, det_bl};
    if (!reset_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 4; i++) begin
      bit srv, rose, all_diff;
      srv  = served(i, La, Lb);
      rose = m_deb[i] && !m_debprev[i];
      // waiting time is judged on the request state before this edge
      if (!m_pend[i] || srv) m_wait[i] = 0;
      else if (m_wait[i] < MW) m_wait[i] = m_wait[i] + 1;
      m_pend[i]    = srv ? 1'b0 : (m_pend[i] | rose);
      m_debprev[i] = m_deb[i];
      // the level flips once DEB consecutive synced samples disagree with it
      hist[i].push_back(m_s2[i]);
      if (hist[i].size() > DEB) void'(hist[i].pop_front());
      all_diff = (hist[i].size() == DEB);
      foreach (hist[i][k]) if (hist[i][k] == m_deb[i]) all_diff = 0;
      if (all_diff) m_deb[i] = !m_deb[i];
      m_s2[i] = m_s1[i];
      m_s1[i] = det[i];
    end
  endtask

  // one clock: update model at the edge, queue expected outputs, move off the edge
  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      exp_q.push_back(model_out());
      #1;
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [7:0] e, a;
      e = exp_q.pop_front();
      a = {Tbl, Tb, Tal, Ta, urgent};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL outputs t=%0t {Tbl,Tb,Tal,Ta,urgent} got=%b exp=%b", $time, a, e);
      end
    end
  end

  task automatic set_det(bit a, bit al, bit b, bit bl);
    det_a = a; det_al = al; det_b = b; det_bl = bl;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    set_det(0, 0, 0, 0);
    La = 2'b10; Lb = 2'b10;
    model_reset();
    #2;
    total++;
    if ({Tbl, Tb, Tal, Ta, urgent} !== 8'h00) begin
      bad++;
      $display("FAIL reset_state got=%b exp=00000000", {Tbl, Tb, Tal, Ta, urgent});
    end
    step(3);
    reset_n = 1'b1;
    step(2);

    // 1. reset mid-cycle while a request is pending and its timer runs
    det_a = 1; La = 2'b10;
    step(12);
    #6;
    reset_n = 1'b0;
    model_reset();
    #1;
    total++;
    if ({Tbl, Tb, Tal, Ta, urgent} !== 8'h00) begin
      bad++;
      $display("FAIL async_reset got=%b exp=00000000", {Tbl, Tb, Tal, Ta, urgent});
    end
    step(2);
    reset_n = 1'b1;
    step(8);
    det_a = 0; La = 2'b00;
    step(6);
    La = 2'b10;

    // 2. short glitch on B straight
    det_b = 1; Lb = 2'b10;
    step(2);
    det_b = 0;
    step(8);

    // 3. latch after the car leaves, then serve with a one-cycle LEFT
    det_al = 1;
    step(6);
    det_al = 0;
    step(8);
    La = 2'b11;
    step(1);
    La = 2'b10;
    step(4);

    // 4. starvation on B left, saturation, then service
    det_bl = 1;
    step(28);
    Lb = 2'b11;
    step(1);
    Lb = 2'b10;
    step(3);
    det_bl = 0;
    Lb = 2'b11;
    step(6);
    Lb = 2'b10;

    // 5. all four together, then A green while still occupied
    set_det(1, 1, 1, 1);
    step(7);
    La = 2'b00;
    step(2);
    det_a = 0;
    step(6);
    La = 2'b11; Lb = 2'b00;
    step(1);
    Lb = 2'b11;
    step(1);
    set_det(0, 0, 0, 0);
    La = 2'b10; Lb = 2'b10;
    step(8);

    // 6. A green the whole time: no latch, T follows the debounced level
    La = 2'b00;
    det_a = 1;
    step(8);
    det_a = 0;
    step(6);
    La = 2'b10;

    // random traffic with glitches and wandering lights
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(7) == 0) det_a  = ~det_a;
      if ($urandom_range(7) == 0) det_al = ~det_al;
      if ($urandom_range(7) == 0) det_b  = ~det_b;
      if ($urandom_range(7) == 0) det_bl = ~det_bl;
      if ($urandom_range(19) == 0) La = 2'($urandom_range(3));
      if ($urandom_range(19) == 0) Lb = 2'($urandom_range(3));
      if ($urandom_range(299) == 0) begin
        #2;
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
      end
      step(1);
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
